// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART transmit and receive paths.
//   DATA_BITS  - payload bits per character (8N1 framing)
//   tx_state_e - serialiser state encoding (IDLE/START/DATA/STOP)
//   baud_div() - clock cycles per line bit, integer division of clock by baud rate
package uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_e;

    function automatic int baud_div(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_byte_tx.sv
// uart_byte_tx: 8N1 byte serialiser, LSB first, each bit held baud_div() cycles.
// Ports:
//   Clk, Reset  - clock, synchronous active-high reset
//   byte_data   - character to send, taken when byte_valid && byte_ready
//   byte_valid  - byte_data offered
//   byte_ready  - serialiser can take a character this cycle (idle, or last stop-bit cycle)
//   byte_done   - high in the last cycle of the stop bit
//   tx          - registered serial line, idle high
// A character offered during the last stop-bit cycle starts its start bit on the
// very next cycle, so consecutive characters follow with no idle gap.
module uart_byte_tx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 115200
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic [DATA_BITS-1:0] byte_data,
    input  logic                 byte_valid,
    output logic                 byte_ready,
    output logic                 byte_done,
    output logic                 tx
);

    localparam int BAUD_DIV = baud_div(CLK_FREQ, BAUD);
    localparam int CNT_W    = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int BIT_W    = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

    tx_state_e              state_q, state_d;
    logic [CNT_W-1:0]       baud_cnt_q, baud_cnt_d;
    logic [BIT_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   tx_q, tx_d;
    logic                   bit_end_s;

    assign bit_end_s  = (baud_cnt_q == CNT_LAST);
    assign byte_done  = (state_q == TX_STOP) && bit_end_s;
    assign byte_ready = (state_q == TX_IDLE) || byte_done;
    assign tx         = tx_q;

    // Next-state, bit timing and next line level for the serialiser
    always_comb begin
        state_d    = state_q;
        baud_cnt_d = baud_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        tx_d       = tx_q;
        case (state_q)
            TX_IDLE: begin
                baud_cnt_d = '0;
                bit_cnt_d  = '0;
                if (byte_valid) begin
                    shift_d = byte_data;
                    tx_d    = 1'b0;
                    state_d = TX_START;
                end else begin
                    tx_d    = 1'b1;
                    state_d = TX_IDLE;
                end
            end
            TX_START: begin
                if (bit_end_s) begin
                    baud_cnt_d = '0;
                    bit_cnt_d  = '0;
                    tx_d       = shift_q[0];
                    state_d    = TX_DATA;
                end else begin
                    baud_cnt_d = baud_cnt_q + CNT_W'(1);
                end
            end
            TX_DATA: begin
                if (bit_end_s) begin
                    baud_cnt_d = '0;
                    if (bit_cnt_q == BIT_LAST) begin
                        tx_d    = 1'b1;
                        state_d = TX_STOP;
                    end else begin
                        // Line shows shift_q[0]; the following bit is shift_q[1]
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                        shift_d   = {1'b0, shift_q[DATA_BITS-1:1]};
                        tx_d      = shift_q[1];
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + CNT_W'(1);
                end
            end
            TX_STOP: begin
                if (bit_end_s) begin
                    baud_cnt_d = '0;
                    bit_cnt_d  = '0;
                    if (byte_valid) begin
                        shift_d = byte_data;
                        tx_d    = 1'b0;
                        state_d = TX_START;
                    end else begin
                        tx_d    = 1'b1;
                        state_d = TX_IDLE;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                baud_cnt_d = '0;
                bit_cnt_d  = '0;
                tx_d       = 1'b1;
                state_d    = TX_IDLE;
            end
        endcase
    end

    // Serialiser state register with synchronous reset to an idle-high line
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= TX_IDLE;
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
        end
    end

endmodule

// File: rtl/uart_pixel_tx.sv
// uart_pixel_tx: sends 16-bit RGB565 pixel words as two 8N1 characters,
// upper byte first, over a UART line.
// Ports:
//   Clk, Reset - clock, synchronous active-high reset
//   pix_data   - pixel word, latched on handshake
//   pix_valid  - pix_data offered
//   pix_ready  - registered; high only while idle, word taken when pix_valid && pix_ready
//   uart_tx    - registered serial line, idle high
//   tx_busy    - registered; from acceptance to end of lower-byte stop bit
//   word_done  - registered one-cycle pulse after the lower-byte stop bit
module uart_pixel_tx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 115200
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [15:0] pix_data,
    input  logic        pix_valid,
    output logic        pix_ready,
    output logic        uart_tx,
    output logic        tx_busy,
    output logic        word_done
);

    logic [15:0] word_q, word_d;
    logic        byte_sel_q, byte_sel_d;   // 0: upper byte on the line, 1: lower byte
    logic        busy_q, busy_d;
    logic        pix_ready_q, pix_ready_d;
    logic        word_done_q, word_done_d;

    logic        pix_accept_s;
    logic        byte_valid_s;
    logic [7:0]  byte_data_s;
    logic        byte_ready_s;
    logic        byte_done_s;

    // pix_ready_q is only set while the serialiser is idle, so an accepted word
    // is handed to it in the same cycle and its start bit follows the accept edge.
    assign pix_accept_s = pix_valid && pix_ready_q;
    // While the upper byte is on the line the lower byte is kept on offer; the
    // serialiser takes it in the last stop-bit cycle, giving a gapless follow-on.
    assign byte_valid_s = busy_q ? !byte_sel_q : pix_accept_s;
    assign byte_data_s  = busy_q ? word_q[7:0] : pix_data[15:8];

    assign pix_ready = pix_ready_q;
    assign tx_busy   = busy_q;
    assign word_done = word_done_q;

    uart_byte_tx #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD)
    ) u_byte_tx (
        .Clk        (Clk),
        .Reset      (Reset),
        .byte_data  (byte_data_s),
        .byte_valid (byte_valid_s),
        .byte_ready (byte_ready_s),
        .byte_done  (byte_done_s),
        .tx         (uart_tx)
    );

    // Word handshake, byte sequencing and completion pulse
    always_comb begin
        word_d      = word_q;
        byte_sel_d  = byte_sel_q;
        busy_d      = busy_q;
        pix_ready_d = pix_ready_q;
        word_done_d = 1'b0;
        if (busy_q) begin
            pix_ready_d = 1'b0;
            if (byte_sel_q && byte_done_s) begin
                busy_d      = 1'b0;
                byte_sel_d  = 1'b0;
                word_done_d = 1'b1;
                pix_ready_d = 1'b1;
            end else if (!byte_sel_q && byte_ready_s) begin
                byte_sel_d = 1'b1;
            end else begin
                byte_sel_d = byte_sel_q;
            end
        end else if (pix_accept_s) begin
            word_d      = pix_data;
            byte_sel_d  = 1'b0;
            busy_d      = 1'b1;
            pix_ready_d = 1'b0;
        end else begin
            pix_ready_d = 1'b1;
        end
    end

    // Word-level registers; reset drops any word in flight without a word_done
    always_ff @(posedge Clk) begin
        if (Reset) begin
            word_q      <= 16'h0000;
            byte_sel_q  <= 1'b0;
            busy_q      <= 1'b0;
            pix_ready_q <= 1'b0;
            word_done_q <= 1'b0;
        end else begin
            word_q      <= word_d;
            byte_sel_q  <= byte_sel_d;
            busy_q      <= busy_d;
            pix_ready_q <= pix_ready_d;
            word_done_q <= word_done_d;
        end
    end

endmodule

// File: tb/tb_uart_pixel_tx.sv
// Self-checking bench for uart_pixel_tx.
// A fast instance (5 MHz / 115200 -> 43 cycles per bit) is checked every cycle
// against a frame-timing model and a loopback receiver; a default instance
// (434 cycles per bit) is checked against a hand-written 0xA55A line pattern.
module tb_uart_pixel_tx;

    localparam int FD     = 43;        // 5_000_000 / 115200
    localparam int FFRAME = 20 * FD;
    localparam int SD     = 434;       // 50_000_000 / 115200
    localparam int SFRAME = 8680;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic [15:0] pix_data = 16'h0000;
    logic        pix_valid = 1'b0;
    logic        pix_ready, uart_tx, tx_busy, word_done;
    logic [15:0] pix_data_f = 16'h0000;
    logic        pix_valid_f = 1'b0;
    logic        pix_ready_f, uart_tx_f, tx_busy_f, word_done_f;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 Clk = ~Clk;

    uart_pixel_tx #(.CLK_FREQ(5_000_000), .BAUD(115200)) dut (
        .Clk(Clk), .Reset(Reset), .pix_data(pix_data), .pix_valid(pix_valid),
        .pix_ready(pix_ready), .uart_tx(uart_tx), .tx_busy(tx_busy), .word_done(word_done)
    );

    uart_pixel_tx dut_full (
        .Clk(Clk), .Reset(Reset), .pix_data(pix_data_f), .pix_valid(pix_valid_f),
        .pix_ready(pix_ready_f), .uart_tx(uart_tx_f), .tx_busy(tx_busy_f), .word_done(word_done_f)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Line level of a word frame at bit slot idx (0..19)
    function automatic logic frame_bit(input logic [15:0] w, input int idx);
        if (idx == 0 || idx == 10) return 1'b0;
        if (idx == 9 || idx == 19) return 1'b1;
        if (idx < 9) return w[8 + idx - 1];
        return w[idx - 11];
    endfunction

    // ---------------- model of the fast instance ----------------
    bit          m_busy = 1'b0, m_ready = 1'b0, m_done = 1'b0;
    int          m_t = 0, m_acc_cnt = 0, rst_gen = 0;
    logic [15:0] m_word = 16'h0000;
    logic [7:0]  exp_q[$];

    initial forever begin
        @(posedge Clk);
        if (Reset) begin
            if (m_busy) begin
                if (exp_q.size() > 0) exp_q.delete(exp_q.size() - 1);
                if (m_t < 10 * FD && exp_q.size() > 0) exp_q.delete(exp_q.size() - 1);
            end
            m_busy = 1'b0; m_ready = 1'b0; m_done = 1'b0;
            rst_gen++;
        end else begin
            m_done = 1'b0;
            if (m_busy) begin
                m_t++;
                if (m_t == FFRAME) begin
                    m_busy = 1'b0; m_done = 1'b1; m_ready = 1'b1;
                end
            end else if (m_ready && pix_valid) begin
                m_busy = 1'b1; m_t = 0; m_ready = 1'b0; m_word = pix_data;
                m_acc_cnt++;
                exp_q.push_back(pix_data[15:8]);
                exp_q.push_back(pix_data[7:0]);
            end else begin
                m_ready = 1'b1;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    int   done_cnt = 0, hi_run = 0;
    bit   gap_en = 1'b0;
    logic prev_tx = 1'b1;

    initial forever begin
        @(negedge Clk);
        check("uart_tx",   uart_tx,   m_busy ? frame_bit(m_word, m_t / FD) : 1'b1);
        check("pix_ready", pix_ready, m_ready);
        check("tx_busy",   tx_busy,   m_busy);
        check("word_done", word_done, m_done);
        if (word_done) done_cnt++;
        if (uart_tx) begin
            hi_run++;
        end else begin
            if (gap_en && m_busy && m_t == 0 && prev_tx) check("interword_high", hi_run, FD + 1);
            hi_run = 0;
        end
        prev_tx = uart_tx;
    end

    // ---------------- loopback receiver ----------------
    logic [7:0] rx_log[$];
    int         rx_g;
    logic [7:0] rx_b;

    initial forever begin
        @(negedge Clk);
        if (!Reset && uart_tx === 1'b0) begin
            rx_g = rst_gen;
            repeat (FD / 2) @(negedge Clk);
            for (int i = 0; i < 8; i++) begin
                repeat (FD) @(negedge Clk);
                rx_b[i] = uart_tx;
            end
            repeat (FD) @(negedge Clk);
            if (rx_g == rst_gen) begin
                check("stop_bit", uart_tx, 1'b1);
                if (exp_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL rx_extra: got byte %0h expected none", rx_b);
                end else begin
                    check("rx_byte", rx_b, exp_q.pop_front());
                end
                rx_log.push_back(rx_b);
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic wait_accept();
        int a = m_acc_cnt;
        int k = 0;
        while (m_acc_cnt == a && k < 3 * FFRAME) begin @(negedge Clk); k++; end
        check("accept_seen", m_acc_cnt != a, 1'b1);
    endtask

    task automatic wait_idle();
        int k = 0;
        while (m_busy && k < 2 * FFRAME) begin @(negedge Clk); k++; end
        check("idle_reached", m_busy, 1'b0);
        repeat (FD) @(negedge Clk);
    endtask

    // Global time limit
    initial begin
        #(1_000_000 * 10);
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic exp_f[20];
        int   base, log0, full_done;
        exp_f = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1,
                  1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

        // 1: reset held 5 cycles, then release
        repeat (5) begin
            @(negedge Clk);
            check("rst_tx", uart_tx, 1'b1);      check("rst_ready", pix_ready, 1'b0);
            check("rst_busy", tx_busy, 1'b0);    check("rst_tx_f", uart_tx_f, 1'b1);
            check("rst_ready_f", pix_ready_f, 1'b0);
        end
        Reset = 1'b0;
        @(negedge Clk);
        check("post_rst_ready", pix_ready, 1'b1);
        check("post_rst_ready_f", pix_ready_f, 1'b1);

        // 2: 0xA55A on the 434-cycle instance against the literal line pattern
        pix_data_f = 16'hA55A; pix_valid_f = 1'b1;
        @(negedge Clk);                          // first cycle after accept edge
        pix_valid_f = 1'b0;
        full_done = 0;
        for (int t = 0; t <= SFRAME; t++) begin
            if (t > 0) @(negedge Clk);
            if (word_done_f) full_done++;
            if (t < SFRAME && (t % SD == 0 || t % SD == SD / 2 || t % SD == SD - 1))
                check("full_tx", uart_tx_f, exp_f[t / SD]);
            if (t >= SFRAME - 1) begin
                check("full_done", word_done_f, t == SFRAME);
                check("full_busy", tx_busy_f, t < SFRAME);
            end
        end
        @(negedge Clk);
        check("full_done_once", full_done, 1);
        check("full_done_clear", word_done_f, 1'b0);

        // 3: back-to-back 0x0000..0x000F with pix_valid held
        base = done_cnt; log0 = rx_log.size();
        for (int w = 0; w < 16; w++) begin
            pix_data = 16'(w); pix_valid = 1'b1;
            wait_accept();
            gap_en = 1'b1;
        end
        pix_valid = 1'b0;
        wait_idle();
        gap_en = 1'b0;
        check("t3_done_pulses", done_cnt - base, 16);
        check("t3_rx_count", rx_log.size() - log0, 32);
        if (rx_log.size() - log0 >= 32)
            for (int i = 0; i < 32; i++)
                check("t3_rx_literal", rx_log[log0 + i], (i % 2 == 0) ? 0 : i / 2);

        // 4: input changes while busy are ignored
        log0 = rx_log.size();
        pix_data = 16'h1234; pix_valid = 1'b1;
        wait_accept();
        repeat (5 * FD) @(negedge Clk);
        pix_data = 16'hFFFF;
        repeat (9 * FD) @(negedge Clk);
        check("t4_ready_low", pix_ready, 1'b0);
        pix_valid = 1'b0;
        wait_idle();
        check("t4_rx_count", rx_log.size() - log0, 2);
        if (rx_log.size() - log0 >= 2) begin
            check("t4_rx_hi", rx_log[log0], 8'h12);
            check("t4_rx_lo", rx_log[log0 + 1], 8'h34);
        end

        // 5: reset during bit 3 of the upper byte, then a clean 0x00FF
        base = done_cnt; log0 = rx_log.size();
        pix_data = 16'hC3A5; pix_valid = 1'b1;
        wait_accept();
        pix_valid = 1'b0;
        for (int k = 0; k < FFRAME && m_t != 4 * FD + 20; k++) @(negedge Clk);
        check("t5_in_bit3", m_t, 4 * FD + 20);
        Reset = 1'b1;
        @(negedge Clk);
        check("t5_line_high", uart_tx, 1'b1);
        Reset = 1'b0;
        repeat (12 * FD) @(negedge Clk);
        pix_data = 16'h00FF; pix_valid = 1'b1;
        wait_accept();
        pix_valid = 1'b0;
        wait_idle();
        check("t5_done_pulses", done_cnt - base, 1);
        check("t5_rx_count", rx_log.size() - log0, 2);
        if (rx_log.size() - log0 >= 2) begin
            check("t5_rx_hi", rx_log[log0], 8'h00);
            check("t5_rx_lo", rx_log[log0 + 1], 8'hFF);
        end

        // Random words, random gaps, random data churn while busy
        for (int n = 0; n < 10; n++) begin
            repeat ($urandom_range(0, 3)) @(negedge Clk);
            pix_data = 16'($urandom); pix_valid = 1'b1;
            wait_accept();
            pix_valid = 1'($urandom_range(0, 1));
            repeat ($urandom_range(1, 4 * FD)) @(negedge Clk);
            pix_data = 16'($urandom);
            pix_valid = 1'b0;
            wait_idle();
        end

        check("exp_q_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
